// File: rtl/async_reset_sequencer.sv
// Reset sequencer: async assert, synchronized + stretched + staggered release.
// Optional RESET_SEQ_CAUSE_EN adds last_cause and sw_rst_cnt outputs.
module async_reset_sequencer #(
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 4,
    parameter int STAGGER        = 2,
    parameter int NUM_DOMAINS    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]             last_cause,
    output logic [7:0]             sw_rst_cnt
`endif
);

    localparam int CMAX =
        (STRETCH_CYCLES > STAGGER) ? STRETCH_CYCLES : STAGGER;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] STR_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] STG_LAST = CW'(STAGGER - 1);

    typedef enum logic [2:0] {
        SYNC,
        STRETCH,
        RELEASE,
        RUN,
        SW_HOLD,
        SW_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0]   rst_q, rst_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     sw_entry;

    assign sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    assign rst_out    = rst_q;
    assign ready      = (state_q == RUN);
    assign sw_rst_ack = (state_q == SW_ACK);

    // State, counter, outputs and sync chain all clear on rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            rst_q   <= '1;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            sync_q  <= sync_d;
        end
    end

    // Next-state: the SYNC exit looks at the last flop's D so the
    // stretch starts on the edge that completes synchronization
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rst_d    = rst_q;
        sw_entry = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (sync_d[SYNC_STAGES-1]) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH, SW_HOLD: begin
                if (cnt_q == STR_LAST) begin
                    cnt_d = '0;
                    if (state_q == STRETCH) begin
                        rst_d   = rst_q << 1;
                        state_d = RELEASE;
                    end else begin
                        state_d = SW_ACK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (rst_q == '0) begin
                    state_d = RUN;
                end else if (cnt_q == STG_LAST) begin
                    rst_d = rst_q << 1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    state_d  = SW_HOLD;
                    rst_d    = '1;
                    cnt_d    = '0;
                    sw_entry = 1'b1;
                end
            end
            SW_ACK: begin
                if (!sw_rst_req) begin
                    state_d = RELEASE;
                    rst_d   = rst_q << 1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause_q;
    logic [7:0] swcnt_q;

    assign last_cause = cause_q;
    assign sw_rst_cnt = swcnt_q;

    // Record reset cause and count SW resets, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= 2'b01;
            swcnt_q <= '0;
        end else if (sw_entry) begin
            cause_q <= 2'b10;
            if (swcnt_q != 8'hFF) begin
                swcnt_q <= swcnt_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_async_reset_sequencer.sv
// Scoreboard bench for async_reset_sequencer (default parameters).
// Build with RESET_SEQ_CAUSE_EN defined to also exercise the cause outputs.
module tb_async_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       ack;
    logic [2:0] rst_out;
    logic       ready;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] last_cause;
    logic [7:0] sw_rst_cnt;
`endif

    async_reset_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (req),
        .sw_rst_ack (ack),
        .rst_out    (rst_out),
        .ready      (ready)
`ifdef RESET_SEQ_CAUSE_EN
        ,
        .last_cause (last_cause),
        .sw_rst_cnt (sw_rst_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] r;
        logic       y;
        logic       a;
        string      nm;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_vec = 0;
    int   n_bad = 0;

    // {rst_out, ready} after boot edge E1..E12
    logic [3:0] boot_tab [1:12] = '{
        4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
        4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0001
    };

    // Monitor: compare on each falling edge, or on demand for async checks
    always begin
        @(negedge clk or chk_ev);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (rst_out !== e.r || ready !== e.y || ack !== e.a) begin
                n_bad++;
                $display("FAIL %s: got rst_out=%b ready=%b ack=%b want %b %b %b",
                         e.nm, rst_out, ready, ack, e.r, e.y, e.a);
            end
        end
    end

    task automatic push(input logic [2:0] r, input logic y,
                        input logic a, input string nm);
        exp_t e;
        e.r  = r;
        e.y  = y;
        e.a  = a;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic rq, input logic [2:0] r,
                        input logic y, input logic a, input string nm);
        req = rq;
        push(r, y, a, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic async_drop(input string nm);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(3'b111, 1'b0, 1'b0, nm);
        ->chk_ev;
    endtask

    task automatic boot(input logic rq, input int upto);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= upto; e++) begin
            step(rq, boot_tab[e][3:1], boot_tab[e][0], 1'b0,
                 $sformatf("boot_e%0d", e));
        end
    endtask

    // From RUN: request at Ek, ack at Ek+4, drop, staggered release
    task automatic sw_cycle(input int hold, input string nm);
        step(1'b1, 3'b111, 1'b0, 1'b0, {nm, "_ek"});
        for (int i = 1; i <= 3; i++)
            step(hold > 0, 3'b111, 1'b0, 1'b0, {nm, "_hold"});
        step(hold > 0, 3'b111, 1'b0, 1'b1, {nm, "_ack"});
        for (int i = 0; i < hold - 1; i++)
            step(1'b1, 3'b111, 1'b0, 1'b1, {nm, "_ackheld"});
        step(1'b0, 3'b110, 1'b0, 1'b0, {nm, "_ej"});
        step(1'b0, 3'b110, 1'b0, 1'b0, {nm, "_ej1"});
        step(1'b0, 3'b100, 1'b0, 1'b0, {nm, "_ej2"});
        step(1'b0, 3'b100, 1'b0, 1'b0, {nm, "_ej3"});
        step(1'b0, 3'b000, 1'b0, 1'b0, {nm, "_ej4"});
        step(1'b0, 3'b000, 1'b1, 1'b0, {nm, "_ej5"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        req   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        push(3'b111, 1'b0, 1'b0, "reset");
        ->chk_ev;

        boot(1'b0, 12);
        step(1'b0, 3'b000, 1'b1, 1'b0, "run_idle");

        async_drop("pre_boot2");
        boot(1'b0, 8);
        async_drop("mid_release");
        step(1'b0, 3'b111, 1'b0, 1'b0, "held_low");
        boot(1'b0, 12);

        async_drop("pre_boot3");
        boot(1'b1, 12);
        sw_cycle(2, "sw_held");

        step(1'b0, 3'b000, 1'b1, 1'b0, "run_gap");
        sw_cycle(0, "sw_pulse");

        async_drop("mid_handshake_pre");
        boot(1'b0, 12);
        step(1'b1, 3'b111, 1'b0, 1'b0, "hs_ek");
        step(1'b1, 3'b111, 1'b0, 1'b0, "hs_ek1");
        async_drop("mid_handshake");
        boot(1'b0, 12);

`ifdef RESET_SEQ_CAUSE_EN
        chk("cause_ext", {30'd0, last_cause}, 32'h1);
        chk("cnt_ext", {24'd0, sw_rst_cnt}, 32'h0);
        for (int n = 0; n < 256; n++) sw_cycle(0, "sw_sat");
        chk("cnt_sat", {24'd0, sw_rst_cnt}, 32'hFF);
        chk("cause_sw", {30'd0, last_cause}, 32'h2);
        async_drop("cause_rst");
        chk("cnt_clr", {24'd0, sw_rst_cnt}, 32'h0);
        chk("cause_clr", {30'd0, last_cause}, 32'h1);
        boot(1'b0, 12);
`endif

        @(negedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
